// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding and frame geometry.
package uart_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_tx_ctrl_baud_tick_gen.sv
// Oversample tick generator: one-clk tick every TICK_DIV cycles, restartable via clear.
module baud_tick_gen #(
  parameter int TICK_DIV = 651
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clear || tick) cnt <= '0;
    else                        cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: 8N1 frames LSB first, started by a one-clk strobe.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int TICK_DIV = CLK_FREQ / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  state_t     state, state_nx;
  logic [7:0] shift, shift_nx;
  logic [3:0] os_cnt;
  logic [2:0] bit_idx;
  logic       tick, accept, bit_end;
  logic       tx_nx, busy_nx, done_nx;

  assign accept  = (state == IDLE) && start;
  assign bit_end = tick && (os_cnt == 4'(OVERSAMPLE - 1));

  // Clearing on accept aligns the first start-bit tick to the accept edge.
  baud_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .tick  (tick)
  );

`ifdef UART_TX_PARITY_EN
  logic parity;

  always_ff @(posedge clk) begin
    if (reset)       parity <= 1'b0;
    else if (accept) parity <= ^tx_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    shift_nx = shift;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = START;
          shift_nx = tx_data;
        end
      end
      START: if (bit_end) state_nx = DATA;
      DATA: begin
        if (bit_end) begin
          shift_nx = shift >> 1;
          if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_nx = STOP;
`endif
      STOP: begin
        if (bit_end) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Line level is decoded from the state being entered so tx is a plain register.
    busy_nx = (state_nx != IDLE);
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift_nx[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_nx = parity;
`endif
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift   <= '0;
      os_cnt  <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      shift <= shift_nx;
      tx    <= tx_nx;
      busy  <= busy_nx;
      done  <= done_nx;
      if (accept) begin
        os_cnt  <= '0;
        bit_idx <= '0;
      end else if ((state != IDLE) && tick) begin
        os_cnt <= os_cnt + 4'd1;
        if ((state == DATA) && bit_end) bit_idx <= bit_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: frame-level line model, independent line decoder, directed scenarios.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int BIT_CYC  = 160;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS    = 11;
  localparam bit PAR_ON   = 1'b1;
`else
  localparam int NBITS    = 10;
  localparam bit PAR_ON   = 1'b0;
`endif
  localparam int FRAME    = NBITS * BIT_CYC;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx, busy, done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  uart_tx_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .tx_data (tx_data),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time exceeded, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  // Frame-level model: a frame is a list of line levels, one per 160-clk bit slot.
  bit         m_ok = 1'b0;
  bit         m_active = 1'b0;
  bit         m_done = 1'b0;
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;

  function automatic logic exp_line(input logic [7:0] b, input int t);
    int slot;
    slot = t / BIT_CYC;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (slot == 9 && PAR_ON) return ^b;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ok = 1'b1; m_active = 1'b0; m_done = 1'b0; m_t = 0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        m_t++;
        if (m_t == FRAME) begin
          m_active = 1'b0;
          m_done = 1'b1;
        end
      end else if (start) begin
        m_active = 1'b1; m_t = 0; m_byte = tx_data;
      end
    end
  end

  int cmp_prints = 0;
  always @(negedge clk) begin
    if (m_ok) begin
      logic etx;
      etx = m_active ? exp_line(m_byte, m_t) : 1'b1;
      checks++;
      if (tx !== etx || busy !== m_active || done !== m_done) begin
        errors++;
        if (cmp_prints < 20) begin
          cmp_prints++;
          $display("FAIL model cyc=%0d: got tx=%b busy=%b done=%b required tx=%b busy=%b done=%b",
                   cyc, tx, busy, done, etx, m_active, m_done);
        end
      end
    end
  end

  // Independent receiver: mid-bit sampling from the falling edge of the start bit.
  bit         rx_on = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_par = 1'b0;
  logic       rx_stop = 1'b0;
  int         rx_frames = 0;
  logic       prev_tx = 1'b1;

  always @(negedge clk) begin
    #1;
    if (reset) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (prev_tx === 1'b1 && tx === 1'b0) begin
        rx_on = 1'b1; rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % BIT_CYC == BIT_CYC / 2) begin
        int b;
        b = rx_cnt / BIT_CYC;
        if (b >= 1 && b <= 8) rx_sh[b-1] = tx;
        if (b == 9 && PAR_ON) rx_par = tx;
        if (b == NBITS - 1) begin
          rx_byte = rx_sh; rx_stop = tx; rx_frames++; rx_on = 1'b0;
        end
      end
    end
    prev_tx = tx;
  end

  int acc;

  task automatic start_now(input logic [7:0] d);
    start = 1'b1; tx_data = d;
    @(negedge clk);
    start = 1'b0;
    acc = cyc;
  endtask

  task automatic track(input int inj_at, input logic [7:0] inj_d,
                       output int lat, output int busy_n);
    lat = -1;
    busy_n = (busy === 1'b1) ? 1 : 0;
    for (int k = 1; k <= FRAME + 50; k++) begin
      @(negedge clk);
      if (k == inj_at) begin start = 1'b1; tx_data = inj_d; end
      else if (k == inj_at + 1) start = 1'b0;
      if (done === 1'b1) begin
        lat = cyc - acc;
        break;
      end
      if (busy === 1'b1) busy_n++;
    end
  endtask

  task automatic idle_window(input int n, output int lows, output int dones);
    lows = 0; dones = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (done === 1'b1) dones++;
    end
  endtask

  initial begin
    int lat, bn, lows, dn, f0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    idle_window(1000, lows, dn);
    chk("idle_tx_low_cycles", lows, 0);
    chk("idle_done_pulses", dn, 0);

    // 8'hA5 with a stray start/8'h3C at accept+500
    f0 = rx_frames;
    start_now(8'hA5);
    chk("a5_first_bit_low", tx, 0);
    track(500, 8'h3C, lat, bn);
    chk("a5_done_latency", lat, PAR_ON ? 1760 : 1600);
    chk("a5_busy_span", bn, PAR_ON ? 1760 : 1600);
    chk("a5_decoded", rx_byte, 8'hA5);
    chk("a5_stop_bit", rx_stop, 1);
    chk("a5_one_frame", rx_frames - f0, 1);
    idle_window(300, lows, dn);
    chk("after_a5_no_queued_frame", lows, 0);
    chk("after_a5_no_extra_done", dn, 0);

    // 8'h81 followed back-to-back by 8'h0F on its done cycle
    @(negedge clk);
    start_now(8'h81);
    track(0, 8'h00, lat, bn);
    chk("81_done_latency", lat, PAR_ON ? 1760 : 1600);
    chk("81_decoded", rx_byte, 8'h81);
    start_now(8'h0F);
    chk("b2b_start_no_gap", tx, 0);
    chk("b2b_busy", busy, 1);
    track(0, 8'h00, lat, bn);
    chk("0f_done_latency", lat, PAR_ON ? 1760 : 1600);
    chk("0f_decoded", rx_byte, 8'h0F);

    // Abort mid-frame at accept+800
    @(negedge clk);
    start_now(8'hC3);
    repeat (799) @(negedge clk);
    chk("abort_pre_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    f0 = rx_frames;
    idle_window(2000, lows, dn);
    chk("abort_idle_low", lows, 0);
    chk("abort_no_done", dn, 0);
    start_now(8'h55);
    track(0, 8'h00, lat, bn);
    chk("55_done_latency", lat, PAR_ON ? 1760 : 1600);
    chk("55_decoded", rx_byte, 8'h55);
    chk("55_one_frame", rx_frames - f0, 1);

`ifdef UART_TX_PARITY_EN
    @(negedge clk);
    start_now(8'h07);
    track(0, 8'h00, lat, bn);
    chk("07_done_latency", lat, 1760);
    chk("07_decoded", rx_byte, 8'h07);
    chk("07_parity_bit", rx_par, 1);
`endif

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Serial UART transmitter that consumes the one-cycle button pulse from the debounce/edge-detect stage as its start strobe.
- Sends one 8-bit frame, LSB first, per accepted start: 1 start bit, 8 data bits, optional parity bit, 1 stop bit.
- Contains its own 16x-oversampled baud tick generator.
- Drives the board TX pin and reports busy/done to the top-level controller.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bits/s.
- TICK_DIV, CLK_FREQ/(BAUD*16): clk cycles per oversample tick. Integer truncation; 651 at the defaults. Must be >= 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-clk request pulse (debounced button edge).
- tx_data  input  8  byte to send; sampled only on the accept cycle.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-clk pulse when a frame completes.

Behaviour:
- Reset, synchronous (one clk, active-high):
  - tx=1, busy=0, done=0.
  - State=IDLE; tick counter, oversample counter, bit index and shift register all cleared.
- Reset asserted mid-frame aborts the frame immediately. On the next edge tx=1 and busy=0, with no done pulse.
- Tick generator:
  - Counts 0..TICK_DIV-1 and emits a one-clk tick on the terminal count.
  - Forced to 0 on the accept cycle so every frame's start bit is aligned.
- Oversample counter: 4-bit, 0..15. A bit period ends on the tick where it equals 15, then it wraps to 0. Each bit lasts exactly 16*TICK_DIV clk cycles.
- FSM states: IDLE, START, DATA, PARITY (only with the feature), STOP.
- IDLE:
  - start=1 is accepted: latch tx_data into the shift register, go to START, set busy=1.
  - tx goes low on the clk edge after the accept cycle (latency 1).
- START: tx=0 for one bit period, then go to DATA with bit index 0.
- DATA:
  - tx=shift[0]; shift right at the end of each bit period.
  - After bit index 7 completes, go to PARITY if enabled, otherwise STOP.
- STOP: tx=1 for one bit period. At its end:
  - Next state is IDLE, busy=0, done=1 for exactly that one cycle.
- start while busy=1 is ignored; it is not queued, and tx_data changes are ignored.
- start coincident with the done cycle is accepted, because state is already IDLE. This gives back-to-back frames with no idle gap.
- Frame length: 10 bits (11 with parity) × 16 × TICK_DIV clk cycles, measured from tx falling to the done pulse.
- All outputs are registered; no combinational path from start to tx.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA.
  - tx = even parity, i.e. the XOR of the latched 8 data bits, for one bit period.
  - Frame is 11 bits.
- Undefined: no PARITY state or parity logic; frame is 10 bits; DATA goes straight to STOP.

Decomposition:
- Shared package/header holds:
  - FSM state encoding localparams: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit.
  - OVERSAMPLE=16.
  - DATA_BITS=8.
- One natural sub-module: baud_tick_gen.
  - Parameter TICK_DIV.
  - Ports clk, reset, clear, tick.
  - uart_tx_ctrl instantiates it and drives clear from the accept cycle.

Test Plan (sim with CLK_FREQ=1_600_000, BAUD=10_000, so TICK_DIV=10 and 160 clk per bit):
- Reset: hold reset 3 clk, then release → tx=1, busy=0, done=0; tx stays 1 for 1000 clk with start=0.
- Single frame: start pulse with tx_data=8'hA5, parity off → tx=0 from accept+1 for 160 clk, then bits 1,0,1,0,0,1,0,1 at 160 clk each, then stop=1. done pulses once at accept+1+1600; busy high for exactly that span.
- Ignored start: pulse start with tx_data=8'h3C at accept+500, mid-frame of 8'hA5 → frame still carries 8'hA5; only one done pulse.
- Back-to-back: assert start with tx_data=8'h0F on the done cycle of the previous frame → the new start bit begins the next clk, no idle high gap; second frame decodes as 8'h0F.
- Reset mid-frame: assert reset at accept+800 → tx=1 and busy=0 the next clk, no done; a later start with 8'h55 transmits cleanly.
- UART_TX_PARITY_EN defined, tx_data=8'h07 → parity bit=1 after the 8 data bits; done at accept+1+1760.
